sw_debounce_encoder: RTL and testbench
======================================

SW_DEBOUNCE_ENCODER -- requirements
Module: sw_debounce_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive cycles a synchronized switch must differ from its stable level before the stable level changes; legal range 2..65535.
REQ-002 Parameter CNT_W, default $clog2(DEBOUNCE_CYCLES): width of each per-channel debounce counter.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 sw_raw_i  input  4  raw asynchronous switches: bit0 power_off, bit1 on, bit2 cleaning, bit3 evading.
REQ-006 sw_stable_o  output  4  debounced switch levels, same bit mapping.
REQ-007 sw_rise_o  output  4  one-cycle pulse per bit when its stable level goes 0->1.
REQ-008 cmd_o  output  2  last accepted command: 00 power_off, 01 on, 10 cleaning, 11 evading; held between commands.
REQ-009 cmd_valid_o  output  1  one-cycle strobe marking a new cmd_o value.
REQ-010 dropped_o  output  1  sticky flag: a lower-priority rise was discarded.

Function
REQ-011 Each sw_raw_i bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Per channel, a counter SHALL increment on each edge where synchronized value != stable level, and SHALL clear to 0 on any edge where they are equal.
REQ-013 On the edge where the counter equals DEBOUNCE_CYCLES-1 and mismatch persists, the stable level SHALL take the synchronized value and the counter SHALL clear.
REQ-014 Latency: with raw held constant, sw_stable_o SHALL change after rising edge DEBOUNCE_CYCLES+2, counting the first edge sampling the new raw value as edge 1.
REQ-015 A raw pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on sw_stable_o, sw_rise_o, or cmd_*.
REQ-016 sw_rise_o[i] SHALL be high exactly in the cycle where sw_stable_o[i] first reads 1; falling transitions SHALL produce no pulse and no command.
REQ-017 Channels SHALL debounce independently; counters saturate never (clear at terminal count).
REQ-018 One cycle after any sw_rise_o bit is high, cmd_valid_o SHALL pulse for one cycle and cmd_o SHALL update in that same cycle.
REQ-019 Command priority on simultaneous rises: power_off > evading > cleaning > on; only the winner is encoded.
REQ-020 If two or more sw_rise_o bits are high in the same cycle, dropped_o SHALL set on the following edge and remain set until rst.
REQ-021 Rises on consecutive cycles SHALL yield back-to-back cmd_valid_o pulses, each with its own cmd_o; none lost, dropped_o unaffected.
REQ-022 Outputs SHALL be registered; no combinational path from sw_raw_i to any output.

Reset
REQ-023 While rst is high at a rising edge: synchronizers, stable levels, counters, sw_rise_o, cmd_valid_o and dropped_o SHALL clear to 0 and cmd_o SHALL be 00.
REQ-024 rst asserted mid-debounce SHALL abort the count; after release a held-high switch SHALL require the full REQ-014 latency again.
REQ-025 Switches already high at reset release SHALL be treated as 0->1 transitions and produce rises and commands after full latency.

Verification
REQ-026 DEBOUNCE_CYCLES=16; raw bit1 0->1 held -> sw_stable_o[1]=1 after edge 18, sw_rise_o=0010 that cycle, next cycle cmd_o=01, cmd_valid_o=1 for one cycle.
REQ-027 Raw bit2 high for 10 cycles then low -> sw_stable_o, sw_rise_o, cmd_valid_o stay 0; cmd_o unchanged.
REQ-028 Raw bits 3 and 0 rise on the same edge and held -> single cmd_valid_o, cmd_o=00, dropped_o=1 and stays 1 until rst.
REQ-029 Bit2 stable high, then raw bit2 bounces 1/0 every 3 cycles for 40 cycles, then held low -> sw_stable_o[2] falls once, after edge 18 of the final hold, no cmd_valid_o.
REQ-030 rst pulsed at counter=12 while raw bit1 held high -> all outputs cleared, cmd_o=00; after release, stable rises after 18 further edges and cmd_o=01.
REQ-031 Bit1 rises, bit2 rises one cycle later -> two consecutive cmd_valid_o pulses with cmd_o=01 then 10; dropped_o=0.

Source files
------------

// File: rtl/sw_debounce_encoder_if.sv
// ---------------------------------------------------------------------------
// sw_debounce_encoder_if
//
// Purpose:
//   Groups the switch inputs and the debounced/encoded outputs of
//   sw_debounce_encoder into one bundle. Clock and reset stay outside the
//   interface as plain ports on the design.
//
// Signals:
//   sw_raw_i     [3:0]  raw asynchronous switches
//                       (bit0 power_off, bit1 on, bit2 cleaning, bit3 evading)
//   sw_stable_o  [3:0]  debounced switch levels, same bit mapping
//   sw_rise_o    [3:0]  one-cycle pulse when a stable level goes 0->1
//   cmd_o        [1:0]  last accepted command (00 power_off, 01 on,
//                       10 cleaning, 11 evading)
//   cmd_valid_o         one-cycle strobe marking a new cmd_o value
//   dropped_o           sticky flag: a lower-priority rise was discarded
//
// Modports:
//   master  drives the switches and observes the outputs (test/system side)
//   slave   the debouncer/encoder itself
// ---------------------------------------------------------------------------
interface sw_debounce_encoder_if;

  logic [3:0] sw_raw_i;
  logic [3:0] sw_stable_o;
  logic [3:0] sw_rise_o;
  logic [1:0] cmd_o;
  logic       cmd_valid_o;
  logic       dropped_o;

  modport master (
    output sw_raw_i,
    input  sw_stable_o,
    input  sw_rise_o,
    input  cmd_o,
    input  cmd_valid_o,
    input  dropped_o
  );

  modport slave (
    input  sw_raw_i,
    output sw_stable_o,
    output sw_rise_o,
    output cmd_o,
    output cmd_valid_o,
    output dropped_o
  );

endinterface

// File: rtl/sw_debounce_encoder.sv
// ---------------------------------------------------------------------------
// sw_debounce_encoder
//
// Purpose:
//   Debounces four mechanical switches and turns their debounced rising
//   edges into a prioritised 2-bit command with a one-cycle valid strobe.
//
//   Pipeline per switch:
//     raw -> 2-flop synchronizer -> debounce counter -> stable level
//   The stable levels feed a rise detector; rises are encoded one cycle
//   later into cmd_o / cmd_valid_o. When several rises land in the same
//   cycle only the highest priority one is encoded
//   (power_off > evading > cleaning > on) and dropped_o is set sticky.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive synchronized cycles a switch must differ
//                    from its stable level before the level flips (2..65535)
//   CNT_W            width of each per-channel debounce counter
//
// Ports:
//   clk   single system clock, all state updates on its rising edge
//   rst   synchronous, active-high reset
//   bus   sw_debounce_encoder_if.slave (switch inputs and all outputs)
//
// All outputs come straight from flops; there is no combinational path
// from sw_raw_i to any output.
// ---------------------------------------------------------------------------
module sw_debounce_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst,
  sw_debounce_encoder_if.slave  bus
);

  // Channel positions inside the 4-bit switch vectors.
  localparam int CH_POWER_OFF = 0;
  localparam int CH_ON        = 1;
  localparam int CH_CLEANING  = 2;
  localparam int CH_EVADING   = 3;

  // Counter value on which a still-persisting mismatch flips the level.
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Encoded command values presented on cmd_o.
  typedef enum logic [1:0] {
    CMD_POWER_OFF = 2'b00,
    CMD_ON        = 2'b01,
    CMD_CLEANING  = 2'b10,
    CMD_EVADING   = 2'b11
  } cmd_e;

  // Synchronizer stages.
  logic [3:0]            sync_q1;
  logic [3:0]            sync_q2;

  // Debounce state.
  logic [3:0]            stable_q;
  logic [3:0]            stable_d;
  logic [3:0][CNT_W-1:0] cnt_q;
  logic [3:0][CNT_W-1:0] cnt_d;
  logic [3:0]            mismatch;

  // Rise detector and command encoder state.
  logic [3:0]            rise_q;
  logic [3:0]            rise_d;
  cmd_e                  cmd_q;
  cmd_e                  cmd_d;
  logic                  cmd_valid_q;
  logic                  dropped_q;
  logic                  multi_rise;

  // Two-flop synchronizer on every raw switch bit. Nothing downstream
  // ever looks at sw_raw_i or sync_q1 directly, only at sync_q2.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= bus.sw_raw_i;
      sync_q2 <= sync_q1;
    end
  end

  // Per-channel debounce decision. The counter tracks how many
  // consecutive edges the synchronized value has disagreed with the
  // stable level; any agreeing edge throws the count away. Once the
  // counter has reached its terminal value and the disagreement is still
  // there, the stable level takes the synchronized value and the counter
  // restarts from zero rather than saturating.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    mismatch = '0;
    for (int i = 0; i < 4; i++) begin
      mismatch[i] = sync_q2[i] ^ stable_q[i];
      if (mismatch[i]) begin
        if (cnt_q[i] == TERM_CNT) begin
          stable_d[i] = sync_q2[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i]    = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A rise is registered on the same edge that the stable level goes
  // 0->1, so sw_rise_o is high exactly in the first cycle the new level
  // is visible. Falling transitions never produce a pulse.
  always_comb begin
    rise_d = stable_d & ~stable_q;
  end

  // Debounce state registers. Reset clears the counters as well, so a
  // reset in the middle of a count forces the full latency again, and a
  // switch held high across reset is seen as a fresh 0->1 transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      cnt_q    <= '0;
      rise_q   <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end

  // Priority encoder over the registered rises. Power_off wins over
  // everything, then evading, cleaning and finally on. With no rise the
  // previous command is held.
  always_comb begin
    cmd_d = cmd_q;
    if (rise_q[CH_POWER_OFF]) begin
      cmd_d = CMD_POWER_OFF;
    end else if (rise_q[CH_EVADING]) begin
      cmd_d = CMD_EVADING;
    end else if (rise_q[CH_CLEANING]) begin
      cmd_d = CMD_CLEANING;
    end else if (rise_q[CH_ON]) begin
      cmd_d = CMD_ON;
    end
  end

  // More than one rise bit set in the same cycle means at least one rise
  // lost arbitration. Clearing the lowest set bit leaves something behind
  // only when two or more bits were set.
  always_comb begin
    multi_rise = |(rise_q & (rise_q - 4'd1));
  end

  // Command output registers. Every cycle with any rise yields exactly
  // one strobe one cycle later, so rises on consecutive cycles come out
  // as back-to-back strobes each carrying its own command.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q       <= CMD_POWER_OFF;
      cmd_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      cmd_valid_q <= |rise_q;
      dropped_q   <= dropped_q | multi_rise;
    end
  end

  // Drive the interface outputs straight from the registers.
  assign bus.sw_stable_o = stable_q;
  assign bus.sw_rise_o   = rise_q;
  assign bus.cmd_o       = cmd_q;
  assign bus.cmd_valid_o = cmd_valid_q;
  assign bus.dropped_o   = dropped_q;

endmodule

// File: tb/tb_sw_debounce_encoder.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce_encoder
//
// Directed bench for sw_debounce_encoder with DEBOUNCE_CYCLES = 16.
// Inputs are driven and outputs sampled 1 time unit after each rising
// clock edge. Every command the stimulus should provoke is queued when the
// stimulus is applied; a monitor pops and compares on each cmd_valid_o.
// ---------------------------------------------------------------------------
module tb_sw_debounce_encoder;

  localparam int DEB = 16;

  typedef struct {
    logic [1:0] cmd;
    logic       dropped;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t exp_q[$];

  sw_debounce_encoder_if bus_if ();

  sw_debounce_encoder #(
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck run still terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n rising edges and settle 1 unit after the last one.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] raw);
    bus_if.sw_raw_i = raw;
  endtask

  task automatic expectCmd(input logic [1:0] cmd, input logic dropped);
    exp_t e;
    e.cmd     = cmd;
    e.dropped = dropped;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard monitor: each strobe must match the oldest queued command.
  always @(posedge clk) begin
    #1;
    if (bus_if.cmd_valid_o === 1'b1) begin
      vectors++;
      assert (exp_q.size() > 0) else begin
        miscompares++;
        $error("[TB] FAIL unexpected_cmd_valid observed=cmd %0h expected=no strobe",
               bus_if.cmd_o);
      end
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        assert (bus_if.cmd_o === e.cmd) else begin
          miscompares++;
          $error("[TB] FAIL sb_cmd observed=%0h expected=%0h", bus_if.cmd_o, e.cmd);
        end
        vectors++;
        assert (bus_if.dropped_o === e.dropped) else begin
          miscompares++;
          $error("[TB] FAIL sb_dropped observed=%0h expected=%0h",
                 bus_if.dropped_o, e.dropped);
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    applyStimulus(4'b0000);
    cyc(3);

    // Reset state.
    checkOutput("rst_stable", bus_if.sw_stable_o, 8'h0);
    checkOutput("rst_rise", bus_if.sw_rise_o, 8'h0);
    checkOutput("rst_cmd", bus_if.cmd_o, 8'h0);
    checkOutput("rst_cmd_valid", bus_if.cmd_valid_o, 8'h0);
    checkOutput("rst_dropped", bus_if.dropped_o, 8'h0);
    rst = 1'b0;
    cyc(3);

    // Single switch 'on': stable after edge 18, command one cycle later.
    applyStimulus(4'b0010);
    expectCmd(2'b01, 1'b0);
    cyc(DEB + 1);
    checkOutput("on_stable_e17", bus_if.sw_stable_o, 8'h0);
    checkOutput("on_rise_e17", bus_if.sw_rise_o, 8'h0);
    cyc(1);
    checkOutput("on_stable_e18", bus_if.sw_stable_o, 8'h2);
    checkOutput("on_rise_e18", bus_if.sw_rise_o, 8'h2);
    checkOutput("on_valid_e18", bus_if.cmd_valid_o, 8'h0);
    cyc(1);
    checkOutput("on_valid_e19", bus_if.cmd_valid_o, 8'h1);
    checkOutput("on_cmd_e19", bus_if.cmd_o, 8'h1);
    checkOutput("on_rise_e19", bus_if.sw_rise_o, 8'h0);
    cyc(1);
    checkOutput("on_valid_e20", bus_if.cmd_valid_o, 8'h0);
    checkOutput("on_cmd_held", bus_if.cmd_o, 8'h1);

    // Release: level falls, no command.
    applyStimulus(4'b0000);
    cyc(DEB + 4);
    checkOutput("on_fall_stable", bus_if.sw_stable_o, 8'h0);
    checkOutput("on_fall_cmd", bus_if.cmd_o, 8'h1);

    // Short glitch on 'cleaning' (10 cycles) is ignored.
    applyStimulus(4'b0100);
    cyc(10);
    applyStimulus(4'b0000);
    cyc(5);
    checkOutput("glitch_stable_mid", bus_if.sw_stable_o, 8'h0);
    cyc(DEB + 4);
    checkOutput("glitch_stable", bus_if.sw_stable_o, 8'h0);
    checkOutput("glitch_cmd", bus_if.cmd_o, 8'h1);

    // 'on' then 'cleaning' one cycle later: two back-to-back strobes.
    applyStimulus(4'b0010);
    expectCmd(2'b01, 1'b0);
    cyc(1);
    applyStimulus(4'b0110);
    expectCmd(2'b10, 1'b0);
    cyc(DEB + 1);
    checkOutput("b2b_rise_a", bus_if.sw_rise_o, 8'h2);
    cyc(1);
    checkOutput("b2b_rise_b", bus_if.sw_rise_o, 8'h4);
    checkOutput("b2b_cmd_a", bus_if.cmd_o, 8'h1);
    checkOutput("b2b_valid_a", bus_if.cmd_valid_o, 8'h1);
    cyc(1);
    checkOutput("b2b_cmd_b", bus_if.cmd_o, 8'h2);
    checkOutput("b2b_valid_b", bus_if.cmd_valid_o, 8'h1);
    checkOutput("b2b_dropped", bus_if.dropped_o, 8'h0);
    applyStimulus(4'b0000);
    cyc(DEB + 4);

    // 'cleaning' stable high, then bouncing, then held low.
    applyStimulus(4'b0100);
    expectCmd(2'b10, 1'b0);
    cyc(DEB + 4);
    checkOutput("bnc_stable_hi", bus_if.sw_stable_o, 8'h4);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(((k / 3) % 2 == 1) ? 4'b0100 : 4'b0000);
      cyc(1);
      checkOutput("bnc_hold_hi", bus_if.sw_stable_o, 8'h4);
    end
    applyStimulus(4'b0000);
    cyc(DEB + 1);
    checkOutput("bnc_stable_e17", bus_if.sw_stable_o, 8'h4);
    cyc(1);
    checkOutput("bnc_stable_e18", bus_if.sw_stable_o, 8'h0);
    checkOutput("bnc_rise_e18", bus_if.sw_rise_o, 8'h0);
    cyc(3);

    // 'evading' and 'power_off' together: power_off wins, dropped sticks.
    applyStimulus(4'b1001);
    expectCmd(2'b00, 1'b1);
    cyc(DEB + 2);
    checkOutput("pri_rise", bus_if.sw_rise_o, 8'h9);
    checkOutput("pri_dropped_pre", bus_if.dropped_o, 8'h0);
    cyc(1);
    checkOutput("pri_valid", bus_if.cmd_valid_o, 8'h1);
    checkOutput("pri_cmd", bus_if.cmd_o, 8'h0);
    checkOutput("pri_dropped", bus_if.dropped_o, 8'h1);
    applyStimulus(4'b0000);
    cyc(DEB + 4);
    checkOutput("pri_dropped_sticky", bus_if.dropped_o, 8'h1);
    checkOutput("pri_stable_low", bus_if.sw_stable_o, 8'h0);

    // Reset in the middle of a count (counter at 12) with 'on' held.
    applyStimulus(4'b0010);
    cyc(14);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    checkOutput("mid_rst_stable", bus_if.sw_stable_o, 8'h0);
    checkOutput("mid_rst_cmd", bus_if.cmd_o, 8'h0);
    checkOutput("mid_rst_dropped", bus_if.dropped_o, 8'h0);
    checkOutput("mid_rst_valid", bus_if.cmd_valid_o, 8'h0);
    expectCmd(2'b01, 1'b0);
    cyc(DEB + 1);
    checkOutput("mid_rst_e17", bus_if.sw_stable_o, 8'h0);
    cyc(1);
    checkOutput("mid_rst_e18", bus_if.sw_stable_o, 8'h2);
    checkOutput("mid_rst_rise", bus_if.sw_rise_o, 8'h2);
    cyc(1);
    checkOutput("mid_rst_cmd_on", bus_if.cmd_o, 8'h1);
    checkOutput("mid_rst_valid_on", bus_if.cmd_valid_o, 8'h1);
    cyc(3);

    // Every queued command must have been produced.
    checkOutput("sb_drain", 8'(exp_q.size()), 8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
